instr_decode_stage: RTL and testbench
=====================================

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL provide parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), value driven on out_instr while no valid instruction is held.
REQ-002 SHALL provide clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide in_valid  input  1  fetch presents an instruction.
REQ-005 SHALL provide in_ready  output  1  stage accepts the instruction this cycle.
REQ-006 SHALL provide in_instr  input  32  fetched instruction word.
REQ-007 SHALL provide in_pc  input  32  PC of in_instr.
REQ-008 SHALL provide flush  input  1  discard held and incoming instruction (branch/jump redirect).
REQ-009 SHALL provide out_valid  output  1  decoded instruction held for execute.
REQ-010 SHALL provide out_ready  input  1  execute consumes the held instruction.
REQ-011 SHALL provide out_instr  output  32  held instruction; bits 31:7 drive the immediate generator's instr input.
REQ-012 SHALL provide out_pc  output  32  PC of held instruction.
REQ-013 SHALL provide out_imm_type  output  3  immediate format code, drives the immediate generator's imm_type_in.
REQ-014 SHALL provide out_rs1, out_rs2, out_rd  output  5 each  register indices instr[19:15], [24:20], [11:7].
REQ-015 SHALL provide out_rs1_en, out_rs2_en, out_rd_we  output  1 each  operand-read and writeback enables.
REQ-016 SHALL provide out_illegal  output  1  held instruction is not decodable.

Function
REQ-017 SHALL be a single-entry pipeline register with 1-cycle latency: instruction accepted at edge N appears on outputs after edge N.
REQ-018 SHALL drive in_ready = !out_valid || out_ready (combinational, no flush dependence).
REQ-019 SHALL load the register when in_valid && in_ready && !flush; out_valid then becomes 1.
REQ-020 SHALL clear out_valid when out_ready && out_valid with no new load in the same cycle.
REQ-021 SHALL hold all outputs stable while out_valid && !out_ready (stall); in_ready is 0.
REQ-022 SHALL, on flush, set out_valid=0 at the next edge and discard any simultaneously offered input; flush overrides load and stall.
REQ-023 SHALL, whenever out_valid=0, drive out_instr=NOP_INSTR, out_imm_type=3'b000, all enables 0, out_illegal=0.
REQ-024 SHALL register decode results (no combinational path from in_instr to out_*).
REQ-025 SHALL decode by opcode instr[6:0] (imm_type / rs1_en rs2_en rd_we):
- 0010011 OP-IMM, 0000011 LOAD, 1100111 JALR: 001 / 1 0 1
- 0100011 STORE: 010 / 1 1 0
- 1100011 BRANCH: 011 / 1 1 0
- 0110111 LUI, 0010111 AUIPC: 100 / 0 0 1
- 1101111 JAL: 101 / 0 0 1
- 0110011 OP: 000 / 1 1 1
- 1110011 SYSTEM, funct3[2]=1 (CSR zimm): 110 / 0 0 1
- 1110011 SYSTEM, funct3 in 001..011: 001 / 1 0 1
- 1110011 SYSTEM, funct3=000 (ecall/ebreak): 000 / 0 0 0
- 1110011 SYSTEM, funct3=100: illegal
- 0001111 FENCE: 000 / 0 0 0
REQ-026 SHALL flag out_illegal=1 for any other opcode, for instr[1:0]!=2'b11, or for SYSTEM funct3=100; imm_type 000 and all enables 0 in that case.
REQ-027 SHALL force out_rd_we=0 when rd=0, regardless of opcode.
REQ-028 SHALL pass out_rs1/out_rs2/out_rd as raw fields even when the matching enable is 0.

Reset
REQ-029 SHALL, when rst=1 at an edge, set out_valid=0, out_pc=32'h0, out_instr=NOP_INSTR, out_imm_type=000, enables and out_illegal 0.
REQ-030 SHALL give rst priority over flush and load; an instruction in flight when rst asserts is lost.
REQ-031 SHALL drive in_ready=1 during and after reset (out_valid=0).

Verification
REQ-032 Reset: rst high 2 cycles with in_valid=1 -> out_valid=0, out_instr=32'h00000013, in_ready=1.
REQ-033 Decode sweep: instr 32'h00A00093 (addi x1,x0,10), pc 32'h100, out_ready=1 -> next cycle out_valid=1, imm_type=001, rs1_en=1, rd_we=1, rd=1, out_pc=32'h100.
REQ-034 Stall: load 32'h00208463 (beq) with out_ready=0 for 3 cycles -> imm_type=011, rd_we=0, in_ready=0, outputs unchanged for 3 cycles.
REQ-035 Flush with simultaneous in_valid: held valid, flush=1, in_valid=1 -> next cycle out_valid=0, offered instruction never appears.
REQ-036 Edge cases: 32'h00000037 (lui x0) -> imm_type=100, rd_we=0; 32'h0000007F -> out_illegal=1; 32'h00005073 (csrrwi x0,…) -> imm_type=110; back-to-back loads with out_ready=1 -> one instruction per cycle, no bubbles.

Source files
------------

// File: rtl/instr_decode_stage.sv
// Single-entry decode pipeline register: classifies the instruction by opcode and registers the results for execute.
// 1-cycle latency, valid/ready handshake; flush and reset empty the stage.
module instr_decode_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [2:0]  out_imm_type,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_rs1_en,
  output logic        out_rs2_en,
  output logic        out_rd_we,
  output logic        out_illegal
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  imm_type_q, imm_type_d;
  logic        rs1_en_q, rs1_en_d;
  logic        rs2_en_q, rs2_en_d;
  logic        rd_we_q, rd_we_d;
  logic        illegal_q, illegal_d;

  logic [2:0]  dec_imm_type;
  logic        dec_rs1_en;
  logic        dec_rs2_en;
  logic        dec_rd_we;
  logic        dec_illegal;
  logic [2:0]  funct3;
  logic        load;

  assign funct3   = in_instr[14:12];
  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    dec_imm_type = 3'b000;
    dec_rs1_en   = 1'b0;
    dec_rs2_en   = 1'b0;
    dec_rd_we    = 1'b0;
    dec_illegal  = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (in_instr[6:0])
        7'b0010011, 7'b0000011, 7'b1100111: begin
          dec_imm_type = 3'b001; dec_rs1_en = 1'b1; dec_rd_we = 1'b1;
        end
        7'b0100011: begin
          dec_imm_type = 3'b010; dec_rs1_en = 1'b1; dec_rs2_en = 1'b1;
        end
        7'b1100011: begin
          dec_imm_type = 3'b011; dec_rs1_en = 1'b1; dec_rs2_en = 1'b1;
        end
        7'b0110111, 7'b0010111: begin
          dec_imm_type = 3'b100; dec_rd_we = 1'b1;
        end
        7'b1101111: begin
          dec_imm_type = 3'b101; dec_rd_we = 1'b1;
        end
        7'b0110011: begin
          dec_rs1_en = 1'b1; dec_rs2_en = 1'b1; dec_rd_we = 1'b1;
        end
        7'b1110011: begin
          // funct3=100 is the one reserved SYSTEM encoding; 000 is ecall/ebreak
          if (funct3 == 3'b100) begin
            dec_illegal = 1'b1;
          end else if (funct3[2]) begin
            dec_imm_type = 3'b110; dec_rd_we = 1'b1;
          end else if (funct3 != 3'b000) begin
            dec_imm_type = 3'b001; dec_rs1_en = 1'b1; dec_rd_we = 1'b1;
          end
        end
        7'b0001111: ;
        default: dec_illegal = 1'b1;
      endcase
    end
    if (in_instr[11:7] == 5'd0) dec_rd_we = 1'b0;
  end

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    imm_type_d = imm_type_q;
    rs1_en_d   = rs1_en_q;
    rs2_en_d   = rs2_en_q;
    rd_we_d    = rd_we_q;
    illegal_d  = illegal_q;
    if (flush || (!load && valid_q && out_ready)) begin
      // Emptying the stage restores the NOP view; the PC is left as-is.
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      imm_type_d = 3'b000;
      rs1_en_d   = 1'b0;
      rs2_en_d   = 1'b0;
      rd_we_d    = 1'b0;
      illegal_d  = 1'b0;
    end else if (load) begin
      valid_d    = 1'b1;
      instr_d    = in_instr;
      pc_d       = in_pc;
      imm_type_d = dec_imm_type;
      rs1_en_d   = dec_rs1_en;
      rs2_en_d   = dec_rs2_en;
      rd_we_d    = dec_rd_we;
      illegal_d  = dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'h0;
      imm_type_q <= 3'b000;
      rs1_en_q   <= 1'b0;
      rs2_en_q   <= 1'b0;
      rd_we_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      imm_type_q <= imm_type_d;
      rs1_en_q   <= rs1_en_d;
      rs2_en_q   <= rs2_en_d;
      rd_we_q    <= rd_we_d;
      illegal_q  <= illegal_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_instr    = instr_q;
  assign out_pc       = pc_q;
  assign out_imm_type = imm_type_q;
  assign out_rs1      = instr_q[19:15];
  assign out_rs2      = instr_q[24:20];
  assign out_rd       = instr_q[11:7];
  assign out_rs1_en   = rs1_en_q;
  assign out_rs2_en   = rs2_en_q;
  assign out_rd_we    = rd_we_q;
  assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Table-driven bench for instr_decode_stage with a scoreboard queue of expected decodes.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  out_imm_type;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_rs1_en, out_rs2_en, out_rd_we, out_illegal;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  imm;
    logic        rs1_en;
    logic        rs2_en;
    logic        rd_we;
    logic        ill;
  } vec_t;

  vec_t vecs[17];
  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;

  instr_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_imm_type(out_imm_type), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_rs1_en(out_rs1_en),
    .out_rs2_en(out_rs2_en), .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic [2:0] imm,
                              input logic r1, input logic r2, input logic we, input logic ill);
    vec_t v;
    v.instr = instr; v.pc = 32'h0; v.imm = imm;
    v.rs1_en = r1; v.rs2_en = r2; v.rd_we = we; v.ill = ill;
    return v;
  endfunction

  task automatic check_held(input vec_t e);
    chk("valid", {31'b0, out_valid}, 32'd1);
    chk("instr", out_instr, e.instr);
    chk("pc", out_pc, e.pc);
    chk("imm_type", {29'b0, out_imm_type}, {29'b0, e.imm});
    chk("rs1", {27'b0, out_rs1}, {27'b0, e.instr[19:15]});
    chk("rs2", {27'b0, out_rs2}, {27'b0, e.instr[24:20]});
    chk("rd", {27'b0, out_rd}, {27'b0, e.instr[11:7]});
    chk("enables", {29'b0, out_rs1_en, out_rs2_en, out_rd_we}, {29'b0, e.rs1_en, e.rs2_en, e.rd_we});
    chk("illegal", {31'b0, out_illegal}, {31'b0, e.ill});
  endtask

  task automatic check_empty(input string tag);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_instr"}, out_instr, NOP);
    chk({tag, "_imm_en_ill"}, {28'b0, out_imm_type, out_rs1_en, out_rs2_en, out_rd_we, out_illegal},
        32'd0);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  // Compare against the oldest expectation, or require an empty stage.
  task automatic check_out();
    vec_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_held(e);
    end else begin
      check_empty("idle");
    end
  endtask

  initial begin
    vec_t e;
    vecs[0]  = mk(32'h00A00093, 3'b001, 1, 0, 1, 0); // addi x1,x0,10
    vecs[1]  = mk(32'h00208463, 3'b011, 1, 1, 0, 0); // beq
    vecs[2]  = mk(32'h00000037, 3'b100, 0, 0, 0, 0); // lui x0
    vecs[3]  = mk(32'h0000007F, 3'b000, 0, 0, 0, 1);
    vecs[4]  = mk(32'h00005073, 3'b110, 0, 0, 0, 0); // csrrwi x0
    vecs[5]  = mk(32'h003100B3, 3'b000, 1, 1, 1, 0); // add x1,x2,x3
    vecs[6]  = mk(32'h0000A083, 3'b001, 1, 0, 1, 0); // lw
    vecs[7]  = mk(32'h00112023, 3'b010, 1, 1, 0, 0); // sw
    vecs[8]  = mk(32'h000080E7, 3'b001, 1, 0, 1, 0); // jalr x1
    vecs[9]  = mk(32'h008000EF, 3'b101, 0, 0, 1, 0); // jal x1
    vecs[10] = mk(32'h00000097, 3'b100, 0, 0, 1, 0); // auipc x1
    vecs[11] = mk(32'h00000073, 3'b000, 0, 0, 0, 0); // ecall
    vecs[12] = mk(32'h000010F3, 3'b001, 1, 0, 1, 0); // csrrw x1
    vecs[13] = mk(32'h00004073, 3'b000, 0, 0, 0, 1); // SYSTEM funct3=100
    vecs[14] = mk(32'h0000000F, 3'b000, 0, 0, 0, 0); // fence
    vecs[15] = mk(32'h00A00090, 3'b000, 0, 0, 0, 1); // low bits != 11
    vecs[16] = mk(32'h00000013, 3'b001, 1, 0, 0, 0); // addi x0: rd_we forced off

    rst = 1'b1; in_valid = 1'b1; in_instr = 32'h00A00093; in_pc = 32'h40;
    flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_empty("reset");
    chk("reset_pc", out_pc, 32'h0);
    rst = 1'b0; in_valid = 1'b0;

    // Back-to-back stream: one decode per cycle with no bubbles.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check_out();
      e = vecs[i];
      e.pc = 32'h100 + 32'(4 * i);
      in_valid = 1'b1; in_instr = e.instr; in_pc = e.pc;
      sb.push_back(e);
    end
    @(negedge clk);
    check_out();
    in_valid = 1'b0;
    @(negedge clk);
    check_out();

    // Stall: beq held for 3 cycles while another instruction is offered.
    e = vecs[1]; e.pc = 32'h200;
    in_valid = 1'b1; in_instr = e.instr; in_pc = e.pc; out_ready = 1'b0;
    @(negedge clk);
    in_instr = 32'h003100B3; in_pc = 32'h204;
    for (int c = 0; c < 3; c++) begin
      check_held(e);
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    check_held(e);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check_empty("drain");

    // Flush with a simultaneous offer: the offered add must never show up.
    e = vecs[0]; e.pc = 32'h300;
    in_valid = 1'b1; in_instr = e.instr; in_pc = e.pc; out_ready = 1'b0;
    @(negedge clk);
    check_held(e);
    flush = 1'b1; in_instr = 32'h003100B3; in_pc = 32'h304;
    @(negedge clk);
    check_empty("flush");
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check_empty("post_flush");

    // Reset wins over a load in flight.
    in_valid = 1'b1; in_instr = 32'h003100B3; in_pc = 32'h400; out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1; in_instr = 32'h0000A083; in_pc = 32'h404;
    @(negedge clk);
    check_empty("rst_in_flight");
    chk("rst_pc", out_pc, 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_empty("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
